serial_adder_ctrl: RTL and testbench

//   Sequencer that time-shares one 1-bit full-adder cell to add two WIDTH-bit operands
//   bit-serially, LSB first, one bit per clock.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/fadd_b.sv | 17 +
 rtl/serial_adder_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_adder_pkg;

   // Sequencer states; 2'd3 is unused and steers back to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Bit-counter width: enough to index bits 0..w-1, never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/fadd_b.sv
// Single-bit full-adder cell shared by the bit-serial sequencer.
module fadd_b (
   input  logic x,
   input  logic y,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   logic w_p;

   // Propagate term is shared between sum and carry.
   assign w_p   = x ^ y;
   assign s     = w_p ^ c_in;
   assign c_out = (x & y) | (c_in & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell is stepped LSB-first across WIDTH bits,
// with the carry held in a flop between steps. Operands are captured on a
// start/ready handshake; sum, carry-out and signed overflow are held until the
// next accept, and done pulses for one cycle when they become valid.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int               CNT_W   = cnt_width(WIDTH);
   // Index of the last bit; the step on this bit finishes the operation.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   // Index of the bit just below the MSB; its carry-out is the carry into the MSB.
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_c_msb;
   logic             r_cout;
   logic             r_ovf;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;

   logic             w_s;
   logic             w_c_out;
   logic [WIDTH-1:0] w_sum_nxt;

   // The one arithmetic element: current LSBs plus the stored carry.
   fadd_b u_fadd (
      .x     (r_a_sh[0]),
      .y     (r_b_sh[0]),
      .c_in  (r_carry),
      .s     (w_s),
      .c_out (w_c_out)
   );

   // New sum bit enters at the MSB while the partial result moves toward the LSB.
   if (WIDTH > 1) begin : g_sum_wide
      assign w_sum_nxt = {w_s, r_sum[WIDTH-1:1]};
   end else begin : g_sum_one
      assign w_sum_nxt = w_s;
   end

   // Sequencer: handshake, bit stepping, result assembly and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the operand shift registers are ordinary flops, not a memory array,
         // so clearing them on reset is cheap and keeps a mid-operation abort clean.
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_c_msb <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         // NOTE: every assignment here is non-blocking so each step reads the
         // pre-edge carry and shift-register values, exactly like a hardware flop.
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_carry <= cin;
                  // Covers WIDTH=1, where cin is itself the carry into the MSB.
                  r_c_msb <= cin;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end

            S_RUN: begin
               r_sum   <= w_sum_nxt;
               r_carry <= w_c_out;
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               if ((WIDTH > 1) && (r_cnt == CNT_PRE)) begin
                  r_c_msb <= w_c_out;
               end
               if (r_cnt == CNT_LAST) begin
                  // Counter stops at the last bit rather than wrapping.
                  r_cout  <= w_c_out;
                  r_ovf   <= r_c_msb ^ w_c_out;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end

            default: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign busy  = r_busy;
   assign done  = r_done;
   assign sum   = r_sum;
   assign cout  = r_cout;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of the bit-serial adder sequencer at WIDTH=8.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   // Present operands with start for one accept edge; returns at the falling edge
   // after the accept edge. With hold=1 start stays asserted afterwards.
   task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tc, input bit hold);
      @(negedge clk);
      a     = ta;
      b     = tb_v;
      cin   = tc;
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Count falling edges until done is seen, bounded at 40.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({ready, busy, done} !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_status: got rdy/busy/done=%b expected 100", {ready, busy, done});
      end
      tests_run++;
      if ({cout, ovf, sum} !== 10'h000) begin
         tests_failed++;
         $display("FAIL reset_result: got cout/ovf/sum=%h expected 000", {cout, ovf, sum});
      end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({ready, busy, done} !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_release: got rdy/busy/done=%b expected 100", {ready, busy, done});
      end
   endtask

   // 0x3C + 0x5A = 0x096; 60+90 exceeds +127, so signed overflow.
   task automatic test_basic();
      int cyc;
      start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
      tests_run++;
      if ({ready, busy, done} !== 3'b010) begin
         tests_failed++;
         $display("FAIL basic_run_status: got rdy/busy/done=%b expected 010", {ready, busy, done});
      end
      wait_done(cyc);
      tests_run++;
      if (cyc !== 8) begin
         tests_failed++;
         $display("FAIL basic_latency: got %0d cycles expected 8", cyc);
      end
      tests_run++;
      if ({cout, ovf, sum} !== {1'b0, 1'b1, 8'h96}) begin
         tests_failed++;
         $display("FAIL basic_result: got cout=%b ovf=%b sum=%h expected 0 1 96", cout, ovf, sum);
      end
      @(negedge clk);
      tests_run++;
      if ({ready, busy, done} !== 3'b100) begin
         tests_failed++;
         $display("FAIL basic_done_pulse: got rdy/busy/done=%b expected 100", {ready, busy, done});
      end
   endtask

   // 0xFF+0x01: carry ripples into and out of the MSB, no overflow.
   // 0x80+0x80: no carry into the MSB but carry out, overflow.
   task automatic test_carry();
      int cyc;
      start_op(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_done(cyc);
      tests_run++;
      if ({cout, ovf, sum} !== {1'b1, 1'b0, 8'h00} || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL carry_ff_01: got done=%b cout=%b ovf=%b sum=%h expected 1 1 0 00", done, cout, ovf, sum);
      end
      @(negedge clk);
      start_op(8'h80, 8'h80, 1'b0, 1'b0);
      wait_done(cyc);
      tests_run++;
      if ({cout, ovf, sum} !== {1'b1, 1'b1, 8'h00} || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL carry_80_80: got done=%b cout=%b ovf=%b sum=%h expected 1 1 1 00", done, cout, ovf, sum);
      end
      @(negedge clk);
   endtask

   // 0xFF+0xFF+1 = 0x1FF. ready stays low from the accept edge through the DONE
   // cycle (WIDTH+1 sampled cycles); the idle cycle makes the op period WIDTH+2.
   task automatic test_all_ones();
      int      low_cnt;
      bit      seen;
      logic [9:0] res;
      start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      low_cnt = 0;
      seen    = 1'b0;
      res     = '0;
      while (ready !== 1'b1 && low_cnt < 20) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            res  = {cout, ovf, sum};
         end
         low_cnt++;
         @(negedge clk);
      end
      tests_run++;
      if (low_cnt !== 9) begin
         tests_failed++;
         $display("FAIL ones_ready_low: got %0d cycles expected 9", low_cnt);
      end
      tests_run++;
      if (!seen || res !== {1'b1, 1'b0, 8'hFF}) begin
         tests_failed++;
         $display("FAIL ones_result: got seen=%b cout/ovf/sum=%h expected 1 2ff", seen, res);
      end
   endtask

   // start and new operands held during RUN must not disturb 0x11+0x22;
   // the held request is accepted only on the edge after ready returns.
   task automatic test_start_during_run();
      int cyc;
      start_op(8'h11, 8'h22, 1'b0, 1'b1);
      a   = 8'h01;
      b   = 8'h00;
      cin = 1'b0;
      wait_done(cyc);
      tests_run++;
      if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'h33} || cyc !== 8) begin
         tests_failed++;
         $display("FAIL run_ignore_result: got cyc=%0d cout=%b ovf=%b sum=%h expected 8 0 0 33", cyc, cout, ovf, sum);
      end
      @(negedge clk);
      tests_run++;
      if ({ready, busy, done} !== 3'b100 || sum !== 8'h33) begin
         tests_failed++;
         $display("FAIL run_ignore_idle: got rdy/busy/done=%b sum=%h expected 100 33", {ready, busy, done}, sum);
      end
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if ({ready, busy} !== 2'b01 || {cout, ovf, sum} !== 10'h000) begin
         tests_failed++;
         $display("FAIL reaccept: got rdy/busy=%b cout/ovf/sum=%h expected 01 000", {ready, busy}, {cout, ovf, sum});
      end
      wait_done(cyc);
      tests_run++;
      if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'h01} || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL reaccept_result: got done=%b sum=%h expected 1 01", done, sum);
      end
      @(negedge clk);
   endtask

   // Reset during RUN aborts silently; the next op runs normally.
   task automatic test_reset_mid_run();
      int cyc;
      bit saw_done;
      start_op(8'h3C, 8'h5A, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if ({ready, busy, done} !== 3'b100 || {cout, ovf, sum} !== 10'h000) begin
         tests_failed++;
         $display("FAIL abort_state: got rdy/busy/done=%b cout/ovf/sum=%h expected 100 000", {ready, busy, done}, {cout, ovf, sum});
      end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      tests_run++;
      if (saw_done || ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_no_done: got saw_done=%b ready=%b expected 0 1", saw_done, ready);
      end
      start_op(8'h10, 8'h20, 1'b0, 1'b0);
      wait_done(cyc);
      tests_run++;
      if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'h30} || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_next_op: got done=%b cout=%b ovf=%b sum=%h expected 1 0 0 30", done, cout, ovf, sum);
      end
      @(negedge clk);
   endtask

   // start tied high: new random operands are presented whenever ready is seen,
   // results are checked against an a+b+cin model and done must recur every 10 cycles.
   task automatic test_back_to_back();
      localparam int N_OPS = 1000;
      logic [7:0] qa[$];
      logic [7:0] qb[$];
      logic       qc[$];
      int         issued, checked, cyc, last_done;
      logic [7:0] ea, eb;
      logic       ec;
      logic [8:0] full;
      logic       eovf;

      issued    = 0;
      checked   = 0;
      cyc       = 0;
      last_done = -1;
      @(negedge clk);
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
      start = 1'b1;
      qa.push_back(a);
      qb.push_back(b);
      qc.push_back(cin);
      issued = 1;
      while (checked < N_OPS && cyc < N_OPS * 10 + 50) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1 && qa.size() > 0) begin
            ea   = qa.pop_front();
            eb   = qb.pop_front();
            ec   = qc.pop_front();
            full = {1'b0, ea} + {1'b0, eb} + {8'h00, ec};
            eovf = (ea[7] == eb[7]) && (full[7] != ea[7]);
            tests_run++;
            if ({cout, ovf, sum} !== {full[8], eovf, full[7:0]}) begin
               tests_failed++;
               $display("FAIL b2b_result op%0d: a=%h b=%h cin=%b got cout=%b ovf=%b sum=%h expected %b %b %h",
                        checked, ea, eb, ec, cout, ovf, sum, full[8], eovf, full[7:0]);
            end
            if (last_done >= 0) begin
               tests_run++;
               if (cyc - last_done !== 10) begin
                  tests_failed++;
                  $display("FAIL b2b_period op%0d: got %0d cycles expected 10", checked, cyc - last_done);
               end
            end
            last_done = cyc;
            checked++;
         end
         if (ready === 1'b1 && issued < N_OPS) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            qa.push_back(a);
            qb.push_back(b);
            qc.push_back(cin);
            issued++;
         end
      end
      start = 1'b0;
      tests_run++;
      if (checked !== N_OPS) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d results expected %0d", checked, N_OPS);
      end
      repeat (12) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_all_ones();
      test_start_during_run();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
